// File: rtl/avr_tx_pkg.sv
// Shared types, constants and the round-robin pick helper for the AVR tx arbiter.
package avr_tx_pkg;

    localparam int unsigned UART_BITS = 8;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid index scanning upward from ptr+1, wrapping modulo n.
    function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        n);
        rr_pick_t    p;
        int unsigned j;
        p.found = 1'b0;
        p.idx   = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= n) j = j - n;
            if (k <= n && !p.found && valid[j[IDX_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = j[IDX_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/avr_tx_arbiter_if.sv
// Requester bus plus AVR-side serial signals for avr_tx_arbiter.
interface avr_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 3
);
    import avr_tx_pkg::*;

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 avr_rx_busy;
    logic                 tx;
    logic [IDX_W-1:0]     grant_id;
    logic                 busy;

    modport master (
        output req_valid, req_data, req_last, avr_rx_busy,
        input  req_ready, tx, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, avr_rx_busy,
        output req_ready, tx, grant_id, busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first; owns the baud and bit counters.
module uart_tx_serializer
    import avr_tx_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             baud_wrap_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // tx_d is the value for the state being entered, so tx stays aligned with state_q.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        baud_wrap_c = (cnt_q == LAST_CNT);

        unique case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                bit_d = '0;
                if (load_i) begin
                    shreg_d = data_i;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_wrap_c) begin
                    cnt_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (baud_wrap_c) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'(1);
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (baud_wrap_c) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/avr_tx_arbiter.sv
// Round-robin arbiter sharing the AVR serial line between NUM_REQ byte producers.
// Optional packet lock: define AVR_TX_PKT_LOCK_EN.
module avr_tx_arbiter
    import avr_tx_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned CLK_PER_BIT = 100
) (
    input logic              clk,
    input logic              rst,
    avr_tx_arbiter_if.slave  bus
);

    logic                 busy_meta_q, busy_sync_q;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]   eligible_c;
    rr_pick_t             pick_c;
    logic                 grant_ok_c;
    logic [7:0]           byte_c;
    logic                 ser_busy;
    logic                 unused_done;

`ifdef AVR_TX_PKT_LOCK_EN
    logic                 lock_q, lock_d;
    logic [IDX_W-1:0]     lock_id_q, lock_id_d;
    logic                 last_c;
`else
    logic                 unused_last_c;
    assign unused_last_c = ^bus.req_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
            rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
            ready_q     <= '0;
            grant_q     <= '0;
`ifdef AVR_TX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
`endif
        end else begin
            busy_meta_q <= bus.avr_rx_busy;
            busy_sync_q <= busy_meta_q;
            rr_ptr_q    <= rr_ptr_d;
            ready_q     <= ready_d;
            grant_q     <= grant_d;
`ifdef AVR_TX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
`endif
        end
    end

    // Arbitration happens only while the serializer is idle and the AVR has room.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        ready_d  = '0;
        grant_d  = grant_q;
        byte_c   = '0;
`ifdef AVR_TX_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        last_c    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible_c[i] = bus.req_valid[i] && (!lock_q || lock_id_q == IDX_W'(i));
        end
`else
        eligible_c = bus.req_valid;
`endif
        pick_c     = rr_next(MAX_REQ'(eligible_c), rr_ptr_q, NUM_REQ);
        grant_ok_c = !ser_busy && !busy_sync_q && pick_c.found;

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_c.idx == IDX_W'(i)) begin
                byte_c     = bus.req_data[8*i +: 8];
                ready_d[i] = grant_ok_c;
`ifdef AVR_TX_PKT_LOCK_EN
                last_c     = bus.req_last[i];
`endif
            end
        end

        if (grant_ok_c) begin
            grant_d  = pick_c.idx;
            rr_ptr_d = pick_c.idx;
`ifdef AVR_TX_PKT_LOCK_EN
            lock_d    = !last_c;
            lock_id_d = pick_c.idx;
`endif
        end
    end

    uart_tx_serializer #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load_i (grant_ok_c),
        .data_i (byte_c),
        .tx_o   (bus.tx),
        .busy_o (ser_busy),
        .done_o (unused_done)
    );

    assign bus.req_ready = ready_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = ser_busy;

endmodule

// File: tb/tb_avr_tx_arbiter.sv
// Directed bench for avr_tx_arbiter (NUM_REQ=3, CLK_PER_BIT=4).
module tb_avr_tx_arbiter;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned CPB     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   lat;
    logic [7:0] rx_byte;

    avr_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    avr_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .CLK_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a ready pulse; lat==max_cyc on timeout.
    task automatic wait_ready(input int max_cyc, output int l);
        l = 0;
        while (bus.req_ready == '0 && l < max_cyc) begin
            tick(1);
            l++;
        end
    endtask

    task automatic expect_grant(input string tag, input int exp_lat, input logic [2:0] id);
        logic [2:0] exp_r;
        int         l;
        exp_r = 3'b001 << id;
        wait_ready(60, l);
        chk({tag, "_lat"},   32'(l),             32'(exp_lat));
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(exp_r));
        chk({tag, "_gid"},   32'(bus.grant_id),  32'(id));
        chk({tag, "_busy"},  32'(bus.busy),      32'd1);
    endtask

    // Called in the first START cycle; returns in the middle of the stop bit.
    task automatic recv(output logic [7:0] b);
        tick(2);
        chk("start_bit", 32'(bus.tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick(CPB);
            b[k] = bus.tx;
        end
        tick(CPB);
        chk("stop_bit", 32'(bus.tx), 32'd1);
    endtask

    initial begin
        bus.req_valid   = '0;
        bus.req_data    = {8'h33, 8'h22, 8'h11};
        bus.req_last    = '1;
        bus.avr_rx_busy = 1'b0;

        tick(3);
        chk("rst_tx",    32'(bus.tx),        32'd1);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_gid",   32'(bus.grant_id),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            tick(1);
            chk("idle", 32'({bus.tx, bus.req_ready, bus.busy}), 32'h10);
        end

        // Single byte 0xA5 from requester 0
        bus.req_data[7:0] = 8'hA5;
        bus.req_valid     = 3'b001;
        expect_grant("single", 1, 3'd0);
        chk("single_tx_start", 32'(bus.tx), 32'd0);
        bus.req_valid     = 3'b000;
        bus.req_data[7:0] = 8'h11;
        recv(rx_byte);
        chk("single_byte",  32'(rx_byte),       32'hA5);
        chk("single_noreq", 32'(bus.req_ready), 32'd0);
        tick(1);
        chk("single_busy_c39", 32'(bus.busy), 32'd1);
        tick(1);
        chk("single_busy_c40", 32'(bus.busy), 32'd0);
        chk("single_tx_idle",  32'(bus.tx),   32'd1);

        // Reset in DATA bit 3 of a byte from requester 1
        bus.req_valid = 3'b111;
        expect_grant("pre_rst", 1, 3'd1);
        tick(17);
        chk("pre_rst_bit3", 32'(bus.tx), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx",    32'(bus.tx),   32'd1);
        chk("rst_mid_busy",  32'(bus.busy), 32'd0);
        tick(2);
        rst = 1'b0;

        // Full rotation, all requesters valid
        expect_grant("rot0", 1, 3'd0);
        recv(rx_byte);
        chk("rot0_byte", 32'(rx_byte), 32'h11);
        expect_grant("rot1", 3, 3'd1);
        recv(rx_byte);
        chk("rot1_byte", 32'(rx_byte), 32'h22);
        expect_grant("rot2", 3, 3'd2);
        recv(rx_byte);
        chk("rot2_byte", 32'(rx_byte), 32'h33);
        expect_grant("rot3", 3, 3'd0);

        // AVR busy mid-byte: byte completes, then no grants until released
        bus.avr_rx_busy = 1'b1;
        recv(rx_byte);
        chk("stall_byte", 32'(rx_byte), 32'h11);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        chk("stall_busy", 32'(bus.busy), 32'd0);
        chk("stall_tx",   32'(bus.tx),   32'd1);
        bus.avr_rx_busy = 1'b0;
        expect_grant("unstall", 3, 3'd1);
        recv(rx_byte);
        chk("unstall_byte", 32'(rx_byte), 32'h22);

`ifdef AVR_TX_PKT_LOCK_EN
        // Requester 1 sends a 3-byte packet while 0 and 2 stay valid
        bus.req_data[15:8] = 8'h41;
        bus.req_last       = 3'b101;
        expect_grant("lk_r2", 3, 3'd2);
        recv(rx_byte);
        chk("lk_r2_byte", 32'(rx_byte), 32'h33);
        expect_grant("lk_r0", 3, 3'd0);
        recv(rx_byte);
        chk("lk_r0_byte", 32'(rx_byte), 32'h11);
        expect_grant("lk_a", 3, 3'd1);
        bus.req_data[15:8] = 8'h42;
        recv(rx_byte);
        chk("lk_a_byte", 32'(rx_byte), 32'h41);
        expect_grant("lk_b", 3, 3'd1);
        bus.req_data[15:8] = 8'h43;
        bus.req_last       = 3'b111;
        recv(rx_byte);
        chk("lk_b_byte", 32'(rx_byte), 32'h42);
        expect_grant("lk_c", 3, 3'd1);
        recv(rx_byte);
        chk("lk_c_byte", 32'(rx_byte), 32'h43);
        expect_grant("lk_after", 3, 3'd2);
        recv(rx_byte);
        chk("lk_after_byte", 32'(rx_byte), 32'h33);
`else
        // req_last has no effect: rotation continues
        bus.req_last = 3'b000;
        expect_grant("nl_r2", 3, 3'd2);
        recv(rx_byte);
        chk("nl_r2_byte", 32'(rx_byte), 32'h33);
        expect_grant("nl_r0", 3, 3'd0);
        recv(rx_byte);
        chk("nl_r0_byte", 32'(rx_byte), 32'h11);
        expect_grant("nl_r1", 3, 3'd1);
        recv(rx_byte);
        chk("nl_r1_byte", 32'(rx_byte), 32'h22);
`endif

        bus.req_valid = '0;
        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
